// File: rtl/denorm_64bits_pipe_pkg.sv
// Shared constants and stage payload for the 64-bit normalize/denormalize paths.
// The payload struct travels through every shifter stage unchanged in shape.
package denorm_64bits_pipe_pkg;

    localparam int WIDTH = 64;
    localparam int SHW   = 6;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sticky;
        logic             v;
        logic [SHW-1:0]   p_rem;
    } stage_payload_t;

    // A zero-flagged value enters as all-zero so no stage can produce stray sticky bits.
    function automatic stage_payload_t entry_payload(
        input logic [WIDTH-1:0] data,
        input logic [SHW-1:0]   p,
        input logic             v
    );
        stage_payload_t pl;
        pl.data   = v ? data : '0;
        pl.sticky = 1'b0;
        pl.v      = v;
        pl.p_rem  = v ? p : '0;
        return pl;
    endfunction

endpackage

// File: rtl/denorm_shift_stage.sv
// One pipeline stage of the right shifter: consumes two bits of the remaining
// shift code (HI_BIT and HI_BIT-1), collects dropped bits into sticky, and registers.
module denorm_shift_stage
    import denorm_64bits_pipe_pkg::*;
#(
    parameter int HI_BIT = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           valid_i,
    output logic           ready_o,
    input  stage_payload_t payload_i,
    output logic           valid_o,
    input  logic           ready_i,
    output stage_payload_t payload_o
);

    localparam int LO_BIT = HI_BIT - 1;
    localparam int SH_HI  = 1 << HI_BIT;
    localparam int SH_LO  = 1 << LO_BIT;
    localparam logic [WIDTH-1:0] MASK_HI = {WIDTH{1'b1}} >> (WIDTH - SH_HI);
    localparam logic [WIDTH-1:0] MASK_LO = {WIDTH{1'b1}} >> (WIDTH - SH_LO);

    logic           valid_q;
    stage_payload_t payload_q;
    stage_payload_t payload_d;
    logic [WIDTH-1:0] lvl1_data;
    logic             lvl1_sticky;
    logic [WIDTH-1:0] lvl2_data;
    logic             lvl2_sticky;
    logic [SHW-1:0]   p_rem_d;

    always_comb begin
        lvl1_data   = payload_i.data;
        lvl1_sticky = payload_i.sticky;
        if (payload_i.p_rem[HI_BIT]) begin
            lvl1_data   = payload_i.data >> SH_HI;
            lvl1_sticky = payload_i.sticky | (|(payload_i.data & MASK_HI));
        end

        lvl2_data   = lvl1_data;
        lvl2_sticky = lvl1_sticky;
        if (payload_i.p_rem[LO_BIT]) begin
            lvl2_data   = lvl1_data >> SH_LO;
            lvl2_sticky = lvl1_sticky | (|(lvl1_data & MASK_LO));
        end

        p_rem_d         = payload_i.p_rem;
        p_rem_d[HI_BIT] = 1'b0;
        p_rem_d[LO_BIT] = 1'b0;

        payload_d        = payload_i;
        payload_d.data   = lvl2_data;
        payload_d.sticky = lvl2_sticky;
        payload_d.p_rem  = p_rem_d;
    end

    // Handshake: a beat moves on valid & ready. This stage is ready when it is
    // empty or its own beat leaves this cycle; valid never depends on ready.
    assign ready_o = ~valid_q | ready_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            if (ready_o) begin
                valid_q <= valid_i;
            end
            if (valid_i && ready_o) begin
                payload_q <= payload_d;
            end
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/denorm_64bits_pipe.sv
// Three-stage pipelined 64-bit denormalizer: out_data = in_data >> in_p with
// sticky collection of all bits shifted out, under valid/ready flow control.
module denorm_64bits_pipe #(
    parameter int WIDTH = 64,
    parameter int SHW   = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_p,
    input  logic             in_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sticky,
    output logic             out_v
);

    import denorm_64bits_pipe_pkg::*;

    stage_payload_t s_in_payload;
    stage_payload_t s0_payload;
    stage_payload_t s1_payload;
    stage_payload_t s2_payload;
    logic           s0_valid;
    logic           s1_valid;
    logic           s1_ready;
    logic           s2_ready;
    logic           s2_p_rem_unused;

    assign s_in_payload = entry_payload(in_data, in_p, in_v);

    denorm_shift_stage #(.HI_BIT(5)) u_stage0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (in_valid),
        .ready_o   (in_ready),
        .payload_i (s_in_payload),
        .valid_o   (s0_valid),
        .ready_i   (s1_ready),
        .payload_o (s0_payload)
    );

    denorm_shift_stage #(.HI_BIT(3)) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (s0_valid),
        .ready_o   (s1_ready),
        .payload_i (s0_payload),
        .valid_o   (s1_valid),
        .ready_i   (s2_ready),
        .payload_o (s1_payload)
    );

    denorm_shift_stage #(.HI_BIT(1)) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_i   (s1_valid),
        .ready_o   (s2_ready),
        .payload_i (s1_payload),
        .valid_o   (out_valid),
        .ready_i   (out_ready),
        .payload_o (s2_payload)
    );

    // The shift code is fully consumed by the last stage.
    assign s2_p_rem_unused = |s2_payload.p_rem;

    assign out_data   = s2_payload.data;
    assign out_sticky = s2_payload.sticky;
    assign out_v      = s2_payload.v;

endmodule

// File: tb/tb_denorm_64bits_pipe.sv
// Bench for denorm_64bits_pipe: directed boundary beats, back-pressure, reset
// mid-flight, lzd round-trip at full rate and random traffic with random stalls.
module tb_denorm_64bits_pipe;

    typedef struct {
        logic [63:0] d;
        logic [5:0]  p;
        logic        v;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [5:0]  in_p;
    logic        in_v;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_sticky;
    logic        out_v;

    beat_t       src_q[$];
    logic [65:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_acc    = 0;
    int n_out    = 0;

    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_acc;
    logic [65:0] s_out;
    logic [65:0] s_last_out;
    logic [65:0] prev_out;
    logic        prev_stall = 1'b0;
    logic        rand_ready = 1'b0;

    always #5 clk = ~clk;

    denorm_64bits_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_p       (in_p),
        .in_v       (in_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .out_v      (out_v)
    );

    // Reference: {v, sticky, data} from plain arithmetic on the whole word.
    function automatic logic [65:0] ref_model(input beat_t b);
        logic [63:0] q;
        logic        st;
        if (!b.v) return 66'd0;
        q  = b.d >> b.p;
        st = (b.p == 6'd0) ? 1'b0 : ((b.d << (7'd64 - {1'b0, b.p})) != 64'd0);
        return {1'b1, st, q};
    endfunction

    function automatic int lzc(input logic [63:0] x);
        for (int i = 63; i >= 0; i--) begin
            if (x[i]) return 63 - i;
        end
        return 64;
    endfunction

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (src_q.size() != 0) begin
            in_valid = 1'b1;
            in_data  = src_q[0].d;
            in_p     = src_q[0].p;
            in_v     = src_q[0].v;
        end else begin
            in_valid = 1'b0;
            in_data  = {$urandom, $urandom};
            in_p     = 6'($urandom_range(0, 63));
            in_v     = 1'($urandom_range(0, 1));
        end
    endtask

    // One clock: drive, sample at negedge, scoreboard, advance to posedge+1.
    task automatic cycle();
        drive();
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        s_in_ready  = in_ready;
        s_out_valid = out_valid;
        s_out       = {out_v, out_sticky, out_data};
        s_acc       = in_valid && in_ready;
        if (prev_stall) begin
            chk("stall_valid", 66'(out_valid), 66'd1);
            chk("stall_hold", s_out, prev_out);
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = s_out;
        if (out_valid && out_ready) begin
            n_out++;
            s_last_out = s_out;
            if (exp_q.size() == 0) chk("spurious_out", 66'(out_valid), 66'd0);
            else chk("scoreboard", s_out, exp_q.pop_front());
        end
        if (s_acc) begin
            exp_q.push_back(ref_model(src_q[0]));
            src_q.delete(0);
            n_acc++;
        end
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic drain(input int budget, input string tag);
        int k = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 66'(src_q.size() + exp_q.size()), 66'd0);
    endtask

    // Beat presented in cycle 0 must show on out_valid in cycle 3, not earlier.
    task automatic check_latency(input beat_t b, input logic [65:0] want, input string tag);
        src_q.push_back(b);
        cycle();
        chk({tag, "_acc"}, 66'(s_acc), 66'd1);
        cycle();
        chk({tag, "_c1"}, 66'(s_out_valid), 66'd0);
        cycle();
        chk({tag, "_c2"}, 66'(s_out_valid), 66'd0);
        cycle();
        chk({tag, "_c3"}, 66'(s_out_valid), 66'd1);
        chk({tag, "_data"}, s_out, want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc0;
        int n_out0;
        int k;
        logic [63:0] x;
        int p;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_p      = '0;
        in_v      = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst_in_ready", 66'(in_ready), 66'd1);
        chk("rst_out_valid", 66'(out_valid), 66'd0);
        chk("rst_out_payload", {out_v, out_sticky, out_data}, 66'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle();
        chk("idle_out_valid", 66'(s_out_valid), 66'd0);

        check_latency('{64'h8000_0000_0000_0000, 6'd5, 1'b1},
                      {1'b1, 1'b0, 64'h0400_0000_0000_0000}, "single_p5");
        check_latency('{64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 1'b1},
                      {1'b1, 1'b1, 64'h0000_0000_0000_0001}, "ones_p63");
        check_latency('{64'hFFFF_FFFF_FFFF_FFFF, 6'd0, 1'b1},
                      {1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, "ones_p0");
        check_latency('{64'hDEAD_BEEF_0000_0001, 6'd10, 1'b0},
                      66'd0, "zero_flag");
        check_latency('{64'h8000_0000_0000_0000, 6'd63, 1'b1},
                      {1'b1, 1'b0, 64'h0000_0000_0000_0001}, "msb_p63");
        check_latency('{64'h0000_F000_0000_0000, 6'd4, 1'b1},
                      {1'b1, 1'b0, 64'h0000_0F00_0000_0000}, "msb_clear");
        check_latency('{64'hFFFF_FFFF_FFFF_FFFF, 6'd1, 1'b1},
                      {1'b1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF}, "ones_p1");
        check_latency('{64'h1234_5678_9ABC_DEF0, 6'd36, 1'b1},
                      {1'b1, 1'b1, 64'h0000_0000_0123_4567}, "mixed_p36");

        // Back-pressure: five beats against a stalled sink.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            src_q.push_back('{{$urandom, $urandom} | 64'h8000_0000_0000_0000,
                              6'($urandom_range(0, 63)), 1'b1});
        end
        n_acc0 = n_acc;
        for (int i = 0; i < 8; i++) cycle();
        chk("bp_accepted", 66'(n_acc - n_acc0), 66'd3);
        chk("bp_in_ready_low", 66'(s_in_ready), 66'd0);
        chk("bp_out_valid", 66'(s_out_valid), 66'd1);
        out_ready = 1'b1;
        #1;
        chk("bp_comb_ready", 66'(in_ready), 66'd1);
        n_out0 = n_out;
        drain(30, "bp_drain");
        chk("bp_out_count", 66'(n_out - n_out0), 66'd5);

        // Reset with two beats in flight.
        src_q.push_back('{64'hC000_0000_0000_0003, 6'd7, 1'b1});
        src_q.push_back('{64'hA000_0000_0000_0005, 6'd9, 1'b1});
        cycle();
        cycle();
        cycle();
        chk("rst_pre_valid", 66'(out_valid), 66'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_out_valid", 66'(out_valid), 66'd0);
        chk("rst_mid_in_ready", 66'(in_ready), 66'd1);
        chk("rst_mid_payload", {out_v, out_sticky, out_data}, 66'd0);
        exp_q.delete();
        src_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rst_no_stale", 66'(s_out_valid), 66'd0);
        end
        check_latency('{64'h9000_0000_0000_0000, 6'd2, 1'b1},
                      {1'b1, 1'b0, 64'h2400_0000_0000_0000}, "post_rst");

        // lzd round-trip at full rate.
        for (int i = 0; i < 10000; i++) begin
            x = {$urandom, $urandom} >> $urandom_range(0, 63);
            if (x == 64'd0) x = 64'd1;
            p = lzc(x);
            src_q.push_back('{x << p, 6'(p), 1'b1});
        end
        k = 0;
        while ((src_q.size() != 0 || exp_q.size() != 0) && k < 10100) begin
            cycle();
            k++;
        end
        chk("rt_cycles", 66'(k), 66'd10003);
        chk("rt_empty", 66'(src_q.size() + exp_q.size()), 66'd0);
        chk("rt_last_sticky", 66'(s_last_out[64]), 66'd0);

        // Random data, shift, zero flag and sink stalls.
        rand_ready = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            src_q.push_back('{{$urandom, $urandom}, 6'($urandom_range(0, 63)),
                              1'($urandom_range(0, 7) != 0)});
        end
        drain(5000, "rand_drain");
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
